// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit a+b+cin one nibble per clock; define NSA_OVF_FLAG_EN for the signed ovf output.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef NSA_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW = $clog2(NIBBLES + 1);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    if (WIDTH < 4 || WIDTH % 4 != 0) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
    logic [WIDTH+3:0] sum_cat;
    logic [CW-1:0]    cnt;
    logic             carry, c;
    logic [3:0]       s4;

    always_comb begin
        {c, s4} = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0, carry};
        sum_cat = {s4, sum_sh};
        sum_nx  = sum_cat[WIDTH+3:4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
`ifdef NSA_OVF_FLAG_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh     <= a;
                    b_sh     <= b;
                    carry    <= cin;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    state    <= ADD;
                end
                ADD: begin
                    a_sh   <= a_sh >> 4;
                    b_sh   <= b_sh >> 4;
                    sum_sh <= sum_nx;
                    carry  <= c;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum       <= sum_nx;
                        cout      <= c;
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef NSA_OVF_FLAG_EN
                        // carry into the MSB is recovered from the MSB's own sum bit
                        ovf       <= c ^ (a_sh[3] ^ b_sh[3] ^ s4[3]);
`endif
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed self-checking bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [15:0] a, b, sum;
    int          checks = 0;
    int          errors = 0;
`ifdef NSA_OVF_FLAG_EN
    logic        ovf;
`endif

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef NSA_OVF_FLAG_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic ci,
                          input logic [15:0] es, input logic ec, input logic eo);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        a = av; b = bv; cin = ci; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = ~av; b = ~bv; cin = ~ci;
        wait_out(tag);
        chk({tag, "_sum"}, {16'b0, sum}, {16'b0, es});
        chk({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
`ifdef NSA_OVF_FLAG_EN
        chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
`else
        if (eo) begin end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", {16'b0, sum}, 32'h0);
        chk("rst_cout", {31'b0, cout}, 32'd0);

        // latency: out_valid appears on the 5th edge counting the accept edge
        a = 16'h0000; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_in_ready_low", {31'b0, in_ready}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("lat_early_valid", {31'b0, out_valid}, 32'd0);
        end
        tick();
        chk("lat_out_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_sum", {16'b0, sum}, 32'h0001);
        chk("lat_cout", {31'b0, cout}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("lat_hs_valid", {31'b0, out_valid}, 32'd0);
        chk("lat_hs_ready", {31'b0, in_ready}, 32'd1);

        run_op("p1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("ripple", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_op("wrap_ci", 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0);
        run_op("wrap_b0", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

        // backpressure plus ignored in_valid pulses while busy
        a = 16'h00F0; b = 16'h0F10; cin = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out("bp");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            tick();
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold_sum", {16'b0, sum}, 32'h1000);
            chk("bp_hold_cout", {31'b0, cout}, 32'd0);
            chk("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp_hs_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_hs_in_ready", {31'b0, in_ready}, 32'd1);
        chk("bp_hs_sum_kept", {16'b0, sum}, 32'h1000);
        tick();
        chk("bp_idle_valid", {31'b0, out_valid}, 32'd0);

        // reset during the second ADD cycle aborts the operation
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_sum", {16'b0, sum}, 32'h0);
        chk("abort_cout", {31'b0, cout}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) tick();
        chk("abort_no_valid", {31'b0, out_valid}, 32'd0);
        run_op("fresh", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

        run_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("uovf", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
